// File: rtl/delay_scan_ctrl_pkg.sv
// Shared types and constants for the delay scan sequencer.
// Build option: DELAY_SCAN_BIDIR_EN enables down-scanning (cfg_dir).
package delay_scan_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int CW_DEFAULT = 16;

  // Fill bits used when a delay step clamps at either end of the range.
  localparam logic SAT_FILL_HI = 1'b1;
  localparam logic SAT_FILL_LO = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETTLE,
    ST_ACQ,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/delay_scan_ctrl_if.sv
// Host/pulse-generator side signals of the delay scan sequencer.
// Build option: DELAY_SCAN_BIDIR_EN adds cfg_dir.
interface delay_scan_ctrl_if
  import delay_scan_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
);
  // start, abort and period_start are single-cycle strobes sampled on every
  // rising clk edge; there is no ready, an ignored strobe is simply dropped.
  logic          start;
  logic          abort;
  logic [DW-1:0] cfg_del_start;
  logic [DW-1:0] cfg_del_step;
  logic [CW-1:0] cfg_npoints;
  logic [CW-1:0] cfg_navg;
`ifdef DELAY_SCAN_BIDIR_EN
  logic          cfg_dir;
`endif
  logic          period_start;
  logic [DW-1:0] del_out;
  logic [CW-1:0] point_idx;
  logic [CW-1:0] avg_idx;
  logic          acq_gate;
  logic          busy;
  logic          done;
  logic          ovf;
  scan_state_t   dbg_state;

  modport master (
    output start, abort, cfg_del_start, cfg_del_step, cfg_npoints, cfg_navg,
`ifdef DELAY_SCAN_BIDIR_EN
    output cfg_dir,
`endif
    output period_start,
    input  del_out, point_idx, avg_idx, acq_gate, busy, done, ovf, dbg_state
  );

  modport slave (
    input  start, abort, cfg_del_start, cfg_del_step, cfg_npoints, cfg_navg,
`ifdef DELAY_SCAN_BIDIR_EN
    input  cfg_dir,
`endif
    input  period_start,
    output del_out, point_idx, avg_idx, acq_gate, busy, done, ovf, dbg_state
  );

endinterface

// File: rtl/delay_scan_ctrl_sat_stepper.sv
// Combinational delay step with clamping; ovf flags a clamped result.
module sat_stepper
  import delay_scan_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] y,
  output logic          ovf
);
  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = sum[DW-1:0];
    ovf  = 1'b0;
    if (sub) begin
      y = diff[DW-1:0];
      // The extra top bit is the borrow out of the subtraction.
      if (diff[DW]) begin
        y   = {DW{SAT_FILL_LO}};
        ovf = 1'b1;
      end
    end else if (sum[DW]) begin
      y   = {DW{SAT_FILL_HI}};
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/delay_scan_ctrl.sv
// Sweeps the pulse-generator delay over a point series, updating only at period boundaries.
// Build option: DELAY_SCAN_BIDIR_EN latches cfg_dir at start to select down-scanning.
module delay_scan_ctrl
  import delay_scan_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int CW     = CW_DEFAULT,
  parameter int SETTLE = 1
) (
  input logic              clk,
  input logic              reset,
  delay_scan_ctrl_if.slave bus
);
  scan_state_t   state;
  logic [DW-1:0] del_q;
  logic [DW-1:0] del_start_q;
  logic [DW-1:0] del_step_q;
  logic [DW-1:0] step_y;
  logic [CW-1:0] npoints_q;
  logic [CW-1:0] navg_q;
  logic [CW-1:0] point_q;
  logic [CW-1:0] avg_q;
  logic [CW-1:0] settle_q;
  logic          acq_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;
  logic          step_ovf;
  logic          dir_q;
  logic          accept;

  // Abort has priority over start, even while idle.
  assign accept = (state == ST_IDLE) && bus.start && !bus.abort;

  sat_stepper #(.DW(DW)) u_stepper (
    .a   (del_q),
    .b   (del_step_q),
    .sub (dir_q),
    .y   (step_y),
    .ovf (step_ovf)
  );

`ifdef DELAY_SCAN_BIDIR_EN
  always_ff @(posedge clk) begin
    if (reset)       dir_q <= 1'b0;
    else if (accept) dir_q <= bus.cfg_dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      del_q       <= '0;
      del_start_q <= '0;
      del_step_q  <= '0;
      npoints_q   <= '0;
      navg_q      <= '0;
      point_q     <= '0;
      avg_q       <= '0;
      settle_q    <= '0;
      acq_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != ST_IDLE && bus.abort) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        acq_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              del_start_q <= bus.cfg_del_start;
              del_step_q  <= bus.cfg_del_step;
              npoints_q   <= bus.cfg_npoints;
              navg_q      <= bus.cfg_navg;
              ovf_q       <= 1'b0;
              point_q     <= '0;
              avg_q       <= '0;
              busy_q      <= 1'b1;
              state       <= (bus.cfg_npoints == '0 || bus.cfg_navg == '0) ? ST_DONE : ST_ARM;
            end
          end
          ST_ARM: begin
            if (bus.period_start) begin
              del_q    <= del_start_q;
              settle_q <= '0;
              state    <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (bus.period_start) begin
              if (settle_q == CW'(SETTLE - 1)) begin
                avg_q <= '0;
                acq_q <= 1'b1;
                state <= ST_ACQ;
              end else begin
                settle_q <= settle_q + CW'(1);
              end
            end
          end
          ST_ACQ: begin
            if (bus.period_start) begin
              if (avg_q == navg_q - CW'(1)) begin
                acq_q <= 1'b0;
                if (point_q == npoints_q - CW'(1)) begin
                  state <= ST_DONE;
                end else begin
                  del_q    <= step_y;
                  ovf_q    <= ovf_q | step_ovf;
                  point_q  <= point_q + CW'(1);
                  avg_q    <= '0;
                  settle_q <= '0;
                  state    <= ST_SETTLE;
                end
              end else begin
                avg_q <= avg_q + CW'(1);
              end
            end
          end
          ST_DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.del_out   = del_q;
  assign bus.point_idx = point_q;
  assign bus.avg_idx   = avg_q;
  assign bus.acq_gate  = acq_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state;

endmodule
